// File: rtl/divu_seq.sv
// Sequential unsigned restoring divider: Q = A / B, R = A % B, one trial subtraction
// per cycle with a start/busy/done handshake and a divide-by-zero flag.
module divu_seq #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic [W-1:0] Q,
   output logic [W-1:0] R,
   output logic         busy,
   output logic         done,
   output logic         dz
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e         state_q;
   logic [W-1:0]   dvd_q;      // dividend, quotient bits shift in at the LSB
   logic [W-1:0]   dvs_q;
   logic [W-1:0]   rem_q;
   logic [CW-1:0]  cnt_q;
   logic [W-1:0]   q_q;
   logic [W-1:0]   r_q;
   logic           dz_q;
   logic           busy_q;
   logic           done_q;

   logic [W:0]     rem_sh_d;
   logic [W+1:0]   diff_d;
   logic           no_borrow_d;
   logic [W-1:0]   rem_d;
   logic [W-1:0]   quo_d;

   // One restoring step. A partial remainder is always < B, so bit W of a
   // non-borrowing trial is 0 and only the low W bits need to be stored.
   always_comb begin
      rem_sh_d    = {rem_q, dvd_q[W-1]};
      diff_d      = {1'b0, rem_sh_d} + {1'b0, ~{1'b0, dvs_q}} + (W+2)'(1);
      no_borrow_d = diff_d[W+1] & ~diff_d[W];
      rem_d       = no_borrow_d ? diff_d[W-1:0] : rem_sh_d[W-1:0];
      quo_d       = {dvd_q[W-2:0], no_borrow_d};
   end

   // NOTE: every register here uses non-blocking assignment so all state updates
   // see the same pre-edge values, regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= (state_q == S_DONE);
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  dvd_q <= A;
                  dvs_q <= B;
                  rem_q <= '0;
                  cnt_q <= CW'(W-1);
                  if (B == '0) begin
                     state_q <= S_DONE;
                     q_q     <= '1;
                     r_q     <= A;
                     dz_q    <= 1'b1;
                  end else begin
                     state_q <= S_RUN;
                     busy_q  <= 1'b1;
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               dvd_q <= quo_d;
               rem_q <= rem_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  q_q     <= quo_d;
                  r_q     <= rem_d;
                  dz_q    <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign Q    = q_q;
   assign R    = r_q;
   assign busy = busy_q;
   assign done = done_q;
   assign dz   = dz_q;

endmodule
